instruction_cache_dm: RTL
=========================

// Module: instruction_cache_dm
// PURPOSE
//  Direct-mapped, read-only instruction cache; directly downstream of the instruction fetch unit.
//  It consumes the fetch PC and returns the instruction word plus a busywait. The fetch unit ORs
//  this busywait with the data-memory busywait to freeze PC. On a miss it fills one block from
//  instruction main memory through a read-only request/busywait handshake.
// PARAMETERS
//  NUM_SETS     8   number of cache lines (power of 2); index = address[INDEX_MSB:4]
//  BLOCK_WORDS  4   32-bit words per line (fixed 4; offset = address[3:2])
//  NOP_INSTR    32'h00000013   word driven when no valid instruction is available
// PORTS
//  clock          in   1    single clock, all state updates on posedge
//  reset          in   1    asynchronous, active-high
//  address        in   32   fetch PC (word aligned; address[1:0] ignored)
//  instruction    out  32   fetched word
//  busywait       out  1    1 = instruction not yet valid, fetch must hold PC
//  mem_read       out  1    read request to instruction main memory
//  mem_address    out  28   block address to memory = latched address[31:4]
//  mem_readdata   in   128  full line from memory; word0 in bits [31:0]
//  mem_busywait   in   1    memory busy; data valid on the edge where it is 0 and mem_read=1
// BEHAVIOUR
//  - Reset (async): all valid bits cleared, FSM=IDLE, mem_read=0, mem_address=0.
//    Outputs are combinational from state: busywait=0, instruction=NOP_INSTR.
//    Tags/data are not cleared.
//  - Address split: tag=address[31:4+log2(NUM_SETS)], index=next log2(NUM_SETS) bits, offset=[3:2].
//  - Post-reset PC: address==32'hFFFFFFFC is a "no fetch" slot.
//    busywait=0, instruction=NOP_INSTR, no miss raised.
//    This lets the fetch unit advance to 0.
//  - hit = valid[index] && tag_array[index]==tag; evaluated combinationally in IDLE.
//  - Hit: same cycle instruction=data[index][offset], busywait=0; zero-cycle latency.
//  - Miss in IDLE: busywait=1 combinationally in the same cycle, instruction=NOP_INSTR.
//    Next posedge: latch address[31:4] into miss_blk and go to MEM_READ.
//  - FSM: IDLE -(miss)-> MEM_READ -(mem_busywait==0)-> UPDATE -> IDLE
//      MEM_READ: mem_read=1, mem_address=miss_blk, busywait=1; stays while mem_busywait=1.
//        On the exit edge, capture mem_readdata into fill register.
//      UPDATE: mem_read=0, busywait=1. On posedge write fill data, tag(miss_blk) and valid=1
//        into line miss_blk index.
//      Back in IDLE the same address now hits. Busywait falls in the first IDLE cycle.
//  - Miss penalty = memory latency + 2 cycles (IDLE detect cycle + UPDATE).
//  - Address changes during MEM_READ/UPDATE do not affect the fill; miss_blk is used.
//    On return to IDLE the current address is re-evaluated, and a new miss may start.
//  - Replacement: the line is always overwritten; there is no dirty state and no writes.
//  - Reset mid-miss: FSM to IDLE and mem_read=0 immediately (async); the partial fill is discarded.
//    The line stays invalid.
//  - mem_read is never asserted outside MEM_READ. busywait is never 1 in IDLE on a hit.
// STRUCTURE
//  - Shared package icache_pkg: state encoding (IDLE=2'd0, MEM_READ=2'd1, UPDATE=2'd2),
//    NOP_INSTR, NO_FETCH_ADDR=32'hFFFFFFFC, widths of tag/index/offset.
//  - One sub-module, icache_line_store: valid/tag/data arrays with a combinational read port
//    (index) and a synchronous write port (we, index, tag, 128-bit data), async clear of valid.
//  - The top holds the FSM, miss_blk/fill registers, hit compare, word mux, output decode.
// TESTING
//  1 reset asserted, address=FFFFFFFC -> busywait=0, instruction=00000013, mem_read=0.
//  2 cold fetch 0x00000000, memory latency 5 -> busywait=1 at once, mem_read=1, mem_address=0.
//    Busywait falls 7 cycles later with instruction=word0.
//  3 after fill of block 0, addresses 0x4, 0x8, 0xC -> each hits same cycle with words 1..3,
//    mem_read never asserted.
//  4 conflict: fetch 0x00000080 (same index 0, tag 1) -> miss and refill.
//    Re-fetch 0x0 -> miss again (line evicted).
//  5 reset pulsed while MEM_READ -> mem_read drops at once, FSM IDLE.
//    Re-fetch of same address misses again (valid=0).
//  6 address switched from 0x10 to 0x20 mid-miss -> line 1 filled with block 0x1.
//    Then a new miss is issued for 0x20 with mem_address=0x2.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Geometry, FSM encoding and fixed instruction constants.
package icache_pkg;

    localparam int NUM_SETS    = 8;
    localparam int BLOCK_WORDS = 4;
    localparam int INDEX_W     = $clog2(NUM_SETS);
    localparam int OFFSET_W    = 2;
    localparam int BLK_W       = 28;
    localparam int TAG_W       = BLK_W - INDEX_W;
    localparam int LINE_W      = 32 * BLOCK_WORDS;

    localparam logic [31:0] NOP_INSTR     = 32'h00000013;
    localparam logic [31:0] NO_FETCH_ADDR = 32'hFFFFFFFC;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_e;

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays for the instruction cache.
// Combinational read port, synchronous write port, async valid clear.
module icache_line_store
    import icache_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [INDEX_W-1:0]  rd_index_i,
    output logic                rd_valid_o,
    output logic [TAG_W-1:0]    rd_tag_o,
    output logic [LINE_W-1:0]   rd_data_o,
    input  logic                we_i,
    input  logic [INDEX_W-1:0]  wr_index_i,
    input  logic [TAG_W-1:0]    wr_tag_i,
    input  logic [LINE_W-1:0]   wr_data_i
);

    logic [NUM_SETS-1:0] valid_q;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [LINE_W-1:0]   data_q [NUM_SETS];

    // Valid bits: cleared asynchronously, set when a line is filled
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    // Tag and data arrays are never cleared; valid gates their use
    always_ff @(posedge clock) begin
        if (we_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/instruction_cache_dm.sv
// Direct-mapped read-only instruction cache with single-line refill.
// Hits return in the same cycle; misses stall fetch via busywait.
module instruction_cache_dm
    import icache_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         address,
    output logic [31:0]         instruction,
    output logic                busywait,
    output logic                mem_read,
    output logic [BLK_W-1:0]    mem_address,
    input  logic [LINE_W-1:0]   mem_readdata,
    input  logic                mem_busywait
);

    state_e              state_q, state_d;
    logic [BLK_W-1:0]    miss_blk_q;
    logic [LINE_W-1:0]   fill_q;

    logic [TAG_W-1:0]    cur_tag;
    logic [INDEX_W-1:0]  cur_index;
    logic [OFFSET_W-1:0] cur_offset;
    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic [LINE_W-1:0]   rd_data;
    logic                no_fetch;
    logic                hit;
    logic                miss;
    logic                line_we;
    logic                unused_addr;

    assign cur_tag     = address[31:4+INDEX_W];
    assign cur_index   = address[4+INDEX_W-1:4];
    assign cur_offset  = address[3:2];
    assign unused_addr = ^address[1:0];

    assign no_fetch = (address == NO_FETCH_ADDR);
    assign hit      = rd_valid && (rd_tag == cur_tag);
    assign miss     = (state_q == IDLE) && !no_fetch && !hit;
    assign line_we  = (state_q == UPDATE);

    icache_line_store u_store (
        .clock      (clock),
        .reset      (reset),
        .rd_index_i (cur_index),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .we_i       (line_we),
        .wr_index_i (miss_blk_q[INDEX_W-1:0]),
        .wr_tag_i   (miss_blk_q[BLK_W-1:INDEX_W]),
        .wr_data_i  (fill_q)
    );

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the missing block and capture the returned line
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            miss_blk_q <= '0;
            fill_q     <= '0;
        end else begin
            if (miss) begin
                miss_blk_q <= address[31:4];
            end
            if (state_q == MEM_READ && !mem_busywait) begin
                fill_q <= mem_readdata;
            end
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        busywait    = 1'b0;
        instruction = NOP_INSTR;
        mem_read    = 1'b0;
        mem_address = '0;
        unique case (state_q)
            IDLE: begin
                if (!no_fetch) begin
                    if (hit) begin
                        instruction = rd_data[{cur_offset, 5'b0} +: 32];
                    end else begin
                        busywait = 1'b1;
                        state_d  = MEM_READ;
                    end
                end
            end
            MEM_READ: begin
                busywait    = 1'b1;
                mem_read    = 1'b1;
                mem_address = miss_blk_q;
                if (!mem_busywait) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                busywait = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
